rcc_rst_seq: RTL and testbench
==============================

// Module: rcc_rst_seq
// PURPOSE
//  Reset sequencer for the RCC. Sits between the board reset/PLL lock and fp_domain root resets.
//  Replaces the plain RSTN & pll_locked gating with the following:
//  - lock filtering
//  - staged, counted release of sys, APB and peripheral-engine resets
//  - software/watchdog re-reset
//  - sticky reset-cause flags
// PARAMETERS
//  LOCK_FILT   16  consecutive synced pll_locked-high cycles required before release (>=1)
//  SYS_DLY      8  cycles from sys_rstn release to apb*_rstn release (>=1)
//  PERIPH_DLY   8  cycles from apb*_rstn release to pe_rstn release (>=1)
//  HOLD_CYC    32  cycles all resets are held after a sw/wdg/lock-loss event (>=1)
// PORTS
//  module_clk   in   1  sequencer clock (sys root clock)
//  module_rstn  in   1  power-on reset: asynchronous, active-low
//  pll_locked   in   1  PLL lock; asynchronous, 2-flop synchronised inside
//  sw_rst_req   in   1  software reset request, 1-cycle pulse, module_clk domain
//  wdg_rst_req  in   1  watchdog reset request, 1-cycle pulse, module_clk domain
//  cause_clr    in   1  clears rst_cause (except bits set in the same cycle)
//  sys_rstn     out  1  sys root reset, active-low, registered
//  apb0_rstn    out  1  APB0 root reset, active-low, registered
//  apb1_rstn    out  1  APB1 root reset, active-low, registered
//  apb2_rstn    out  1  APB2 root reset, active-low, registered
//  pe_rstn      out  1  eth tx/rx + advtim engine reset, active-low, registered
//  rst_busy     out  1  1 whenever state != RUN
//  rst_cause    out  4  sticky cause flags: {lock_loss, wdg, sw, por}
// BEHAVIOUR
//  - Reset: module_rstn low asynchronously clears all flops.
//    - State WAIT_LOCK.
//    - All *_rstn = 0, rst_busy = 1.
//    - rst_cause = 4'b0001.
//  - Outputs are module_clk registers. Consumers in other clock domains resynchronise the deassertion edge.
//  - lk = pll_locked after 2 flops (2-cycle latency). Counters are sized $clog2(max param + 1).
//  - FSM: WAIT_LOCK -> SYS_REL -> APB_REL -> RUN; any state -> HOLD -> WAIT_LOCK.
//  - WAIT_LOCK:
//    - lk=1 increments lock_cnt; lk=0 clears it.
//    - Leaves when lk=1 and lock_cnt==LOCK_FILT-1.
//    - On that cycle: sys_rstn<=1, cnt<=0, next SYS_REL.
//  - SYS_REL: counts SYS_DLY cycles, then apb0/1/2_rstn<=1 together, cnt<=0, next APB_REL.
//  - APB_REL: counts PERIPH_DLY cycles, then pe_rstn<=1, next RUN, rst_busy<=0.
//  - A clean first release therefore needs 2 + LOCK_FILT + SYS_DLY + PERIPH_DLY cycles from the module_rstn deassert edge to pe_rstn=1.
//  - sw_rst_req or wdg_rst_req in any state:
//    - Next cycle: all *_rstn=0, state HOLD, hold_cnt=0.
//    - Set cause bit(s). Simultaneous sw+wdg sets both bits.
//  - HOLD: counts HOLD_CYC cycles, then WAIT_LOCK with lock_cnt=0.
//  - Any request during HOLD restarts hold_cnt at 0 and sets its cause bit.
//  - rst_cause:
//    - Bits are set only by events; no bit clears another.
//    - cause_clr zeros all bits, but a bit set in the same cycle wins.
//    - Only module_rstn sets por.
//  - Release order is strict at every boundary:
//    - sys is never released after apb, and apb never after pe.
//    - All outputs assert (drop) in the same cycle.
// CONFIGURATION
//  RCC_LOCK_LOSS_RST_EN
//   defined: lk=0 in SYS_REL, APB_REL or RUN -> HOLD next cycle, sets rst_cause[3].
//     - This uses the same path as sw/wdg, followed by a full re-lock filter.
//   undefined: lk is ignored outside WAIT_LOCK, and rst_cause[3] stays 0.
//  In WAIT_LOCK, lk=0 clears lock_cnt in both builds.
// TESTING
//  1. Defaults, pll_locked=1 from t0, release module_rstn:
//     - sys_rstn rises at cycle 18.
//     - apb0/1/2 rise at 26, pe_rstn at 34, rst_busy=0 at 34.
//     - rst_cause=4'b0001.
//  2. pll_locked high 10 cycles, low 1, then high:
//     - lock_cnt restarts; sys_rstn rises 16+2 cycles after the second rise.
//  3. In RUN, pulse sw_rst_req:
//     - All *_rstn=0 next cycle for 32 cycles, then relock 16, then staged release.
//     - rst_cause=4'b0011.
//  4. sw_rst_req and wdg_rst_req in the same cycle, then wdg again at hold_cnt=20:
//     - Hold extends to 20+1+32 cycles.
//     - rst_cause=4'b0111.
//  5. In RUN, drop pll_locked for 1 cycle:
//     - With RCC_LOCK_LOSS_RST_EN: HOLD, rst_cause[3]=1.
//     - Without it: outputs stay 1, cause unchanged.
//  6. cause_clr in the same cycle as wdg_rst_req -> rst_cause=4'b0100.
//     module_rstn low in APB_REL -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/rcc_rst_seq.sv
// rcc_rst_seq: RCC reset sequencer.
// Filters PLL lock, releases sys -> apb0/1/2 -> pe resets in counted stages,
// re-resets on software/watchdog requests and keeps sticky reset-cause flags.
// Optional build macro: RCC_LOCK_LOSS_RST_EN (loss of lock after release forces a re-reset).
module rcc_rst_seq #(
  parameter int unsigned LOCK_FILT  = 16,
  parameter int unsigned SYS_DLY    = 8,
  parameter int unsigned PERIPH_DLY = 8,
  parameter int unsigned HOLD_CYC   = 32
) (
  input  logic       module_clk,
  input  logic       module_rstn,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  input  logic       wdg_rst_req,
  input  logic       cause_clr,
  output logic       sys_rstn,
  output logic       apb0_rstn,
  output logic       apb1_rstn,
  output logic       apb2_rstn,
  output logic       pe_rstn,
  output logic       rst_busy,
  output logic [3:0] rst_cause
);

  // One counter serves lock filter, stage delays and hold: the states are exclusive.
  localparam int unsigned MAX_A = (LOCK_FILT > SYS_DLY) ? LOCK_FILT : SYS_DLY;
  localparam int unsigned MAX_B = (PERIPH_DLY > HOLD_CYC) ? PERIPH_DLY : HOLD_CYC;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_P + 32'd1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILT - 32'd1);
  localparam logic [CW-1:0] SYS_LAST  = CW'(SYS_DLY - 32'd1);
  localparam logic [CW-1:0] PE_LAST   = CW'(PERIPH_DLY - 32'd1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 32'd1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SYS_REL   = 3'd1,
    ST_APB_REL   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          pll_sync_r;
  logic          lk_r;
  logic          lock_loss_s;
  logic          event_s;
  logic [3:0]    cause_set_s;
  logic [3:0]    cause_nxt_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge module_clk or negedge module_rstn) begin
    if (!module_rstn) begin
      pll_sync_r <= 1'b0;
      lk_r       <= 1'b0;
    end else begin
      pll_sync_r <= pll_locked;
      lk_r       <= pll_sync_r;
    end
  end

`ifdef RCC_LOCK_LOSS_RST_EN
  assign lock_loss_s = !lk_r && ((state_r == ST_SYS_REL) ||
                                 (state_r == ST_APB_REL) ||
                                 (state_r == ST_RUN));
`else
  assign lock_loss_s = 1'b0;
`endif

  assign event_s     = sw_rst_req | wdg_rst_req | lock_loss_s;
  assign cause_set_s = {lock_loss_s, wdg_rst_req, sw_rst_req, 1'b0};

  // Cause flags: clear drops old bits, events raised this cycle always survive.
  always_comb begin
    cause_nxt_s = rst_cause;
    if (cause_clr) begin
      cause_nxt_s = cause_set_s;
    end else begin
      cause_nxt_s = rst_cause | cause_set_s;
    end
  end

  // Sticky reset-cause register; only power-on reset sets the por bit.
  always_ff @(posedge module_clk or negedge module_rstn) begin
    if (!module_rstn) begin
      rst_cause <= 4'b0001;
    end else begin
      rst_cause <= cause_nxt_s;
    end
  end

  // Sequencer FSM with registered reset outputs; any event overrides every state.
  always_ff @(posedge module_clk or negedge module_rstn) begin
    if (!module_rstn) begin
      state_r   <= ST_WAIT_LOCK;
      cnt_r     <= CNT_ZERO;
      sys_rstn  <= 1'b0;
      apb0_rstn <= 1'b0;
      apb1_rstn <= 1'b0;
      apb2_rstn <= 1'b0;
      pe_rstn   <= 1'b0;
      rst_busy  <= 1'b1;
    end else if (event_s) begin
      state_r   <= ST_HOLD;
      cnt_r     <= CNT_ZERO;
      sys_rstn  <= 1'b0;
      apb0_rstn <= 1'b0;
      apb1_rstn <= 1'b0;
      apb2_rstn <= 1'b0;
      pe_rstn   <= 1'b0;
      rst_busy  <= 1'b1;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (!lk_r) begin
            cnt_r <= CNT_ZERO;
          end else if (cnt_r == LOCK_LAST) begin
            sys_rstn <= 1'b1;
            cnt_r    <= CNT_ZERO;
            state_r  <= ST_SYS_REL;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SYS_REL: begin
          if (cnt_r == SYS_LAST) begin
            apb0_rstn <= 1'b1;
            apb1_rstn <= 1'b1;
            apb2_rstn <= 1'b1;
            cnt_r     <= CNT_ZERO;
            state_r   <= ST_APB_REL;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_APB_REL: begin
          if (cnt_r == PE_LAST) begin
            pe_rstn  <= 1'b1;
            rst_busy <= 1'b0;
            cnt_r    <= CNT_ZERO;
            state_r  <= ST_RUN;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_WAIT_LOCK;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= ST_WAIT_LOCK;
          cnt_r     <= CNT_ZERO;
          sys_rstn  <= 1'b0;
          apb0_rstn <= 1'b0;
          apb1_rstn <= 1'b0;
          apb2_rstn <= 1'b0;
          pe_rstn   <= 1'b0;
          rst_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_rst_seq.sv
// tb_rcc_rst_seq: directed and randomized bench for rcc_rst_seq.
// The reference model tracks elapsed-cycle ages (hold age, lock-filter run,
// age since sys release) and derives every output from those ages.
module tb_rcc_rst_seq;

  localparam int LOCK_FILT  = 16;
  localparam int SYS_DLY    = 8;
  localparam int PERIPH_DLY = 8;
  localparam int HOLD_CYC   = 32;

  logic       clk;
  logic       rst_n;
  logic       pll;
  logic       sw;
  logic       wdg;
  logic       clr;
  logic       sys_rstn;
  logic       apb0_rstn;
  logic       apb1_rstn;
  logic       apb2_rstn;
  logic       pe_rstn;
  logic       rst_busy;
  logic [3:0] rst_cause;

  int checks;
  int errors;
  int f_sys;
  int f_apb;
  int f_pe;

  // reference model state
  logic       m_p1;
  logic       m_p2;
  logic [3:0] m_cause;
  logic       m_in_hold;
  int         m_hold_age;
  int         m_filt;
  int         m_rel_age;

  rcc_rst_seq #(
    .LOCK_FILT  (LOCK_FILT),
    .SYS_DLY    (SYS_DLY),
    .PERIPH_DLY (PERIPH_DLY),
    .HOLD_CYC   (HOLD_CYC)
  ) dut (
    .module_clk  (clk),
    .module_rstn (rst_n),
    .pll_locked  (pll),
    .sw_rst_req  (sw),
    .wdg_rst_req (wdg),
    .cause_clr   (clr),
    .sys_rstn    (sys_rstn),
    .apb0_rstn   (apb0_rstn),
    .apb1_rstn   (apb1_rstn),
    .apb2_rstn   (apb2_rstn),
    .pe_rstn     (pe_rstn),
    .rst_busy    (rst_busy),
    .rst_cause   (rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_p1       = 1'b0;
    m_p2       = 1'b0;
    m_cause    = 4'b0001;
    m_in_hold  = 1'b0;
    m_hold_age = 0;
    m_filt     = 0;
    m_rel_age  = -1;
  endtask

  // One clock edge of the reference model; lk is the lock level sampled two edges ago.
  task automatic m_edge(input logic p, input logic s, input logic w, input logic c);
    logic lk;
    logic ll;
    lk   = m_p2;
    m_p2 = m_p1;
    m_p1 = p;
    ll   = 1'b0;
`ifdef RCC_LOCK_LOSS_RST_EN
    ll = !lk && (m_rel_age >= 0);
`endif
    m_cause = (c ? 4'b0000 : m_cause) | {ll, w, s, 1'b0};
    if (s || w || ll) begin
      m_in_hold  = 1'b1;
      m_hold_age = 0;
      m_rel_age  = -1;
      m_filt     = 0;
    end else if (m_in_hold) begin
      m_hold_age++;
      if (m_hold_age == HOLD_CYC) begin
        m_in_hold = 1'b0;
        m_filt    = 0;
      end
    end else if (m_rel_age >= 0) begin
      if (m_rel_age < 100000) m_rel_age++;
    end else if (lk) begin
      m_filt++;
      if (m_filt == LOCK_FILT) m_rel_age = 0;
    end else begin
      m_filt = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic e_sys;
    logic e_apb;
    logic e_pe;
    e_sys = (m_rel_age >= 0);
    e_apb = (m_rel_age >= SYS_DLY);
    e_pe  = (m_rel_age >= SYS_DLY + PERIPH_DLY);
    check_bit({tag, "_sys"},  sys_rstn,  e_sys);
    check_bit({tag, "_apb0"}, apb0_rstn, e_apb);
    check_bit({tag, "_apb1"}, apb1_rstn, e_apb);
    check_bit({tag, "_apb2"}, apb2_rstn, e_apb);
    check_bit({tag, "_pe"},   pe_rstn,   e_pe);
    check_bit({tag, "_busy"}, rst_busy,  !e_pe);
    check_vec({tag, "_cause"}, rst_cause, m_cause);
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare just after it.
  task automatic step(input logic p, input logic s, input logic w, input logic c);
    pll = p;
    sw  = s;
    wdg = w;
    clr = c;
    @(posedge clk);
    m_edge(p, s, w, c);
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_rise();
    f_sys = 0;
    f_apb = 0;
    f_pe  = 0;
  endtask

  task automatic note_rise(input int k);
    if (sys_rstn === 1'b1 && f_sys == 0) f_sys = k;
    if (apb0_rstn === 1'b1 && f_apb == 0) f_apb = k;
    if (pe_rstn === 1'b1 && f_pe == 0) f_pe = k;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    pll    = 1'b1;
    sw     = 1'b0;
    wdg    = 1'b0;
    clr    = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");

    // 1: clean first release with lock present from the start
    rst_n = 1'b1;
    clear_rise();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      note_rise(k);
    end
    check_int("t1_sys_rise", f_sys, 18);
    check_int("t1_apb_rise", f_apb, 26);
    check_int("t1_pe_rise", f_pe, 34);
    check_vec("t1_cause", rst_cause, 4'b0001);

    // 2: lock glitch restarts the filter
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    clear_rise();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      note_rise(k);
    end
    check_int("t2_sys_rise", f_sys, 18);

    // 3: software reset from RUN
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("t3_sys_low", sys_rstn, 1'b0);
    check_vec("t3_cause", rst_cause, 4'b0011);
    clear_rise();
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      note_rise(k);
    end
    check_int("t3_sys_rise", f_sys, 48);
    check_int("t3_pe_rise", f_pe, 64);

    // 4: simultaneous sw+wdg, then wdg again at hold count 20
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    clear_rise();
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      note_rise(k);
    end
    check_int("t4_sys_rise", f_sys, 48);
    check_vec("t4_cause", rst_cause, 4'b0111);

    // 5: one-cycle lock drop in RUN
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef RCC_LOCK_LOSS_RST_EN
    check_bit("t5_sys", sys_rstn, 1'b0);
    check_vec("t5_cause", rst_cause, 4'b1111);
`else
    check_bit("t5_sys", sys_rstn, 1'b1);
    check_vec("t5_cause", rst_cause, 4'b0111);
`endif
    for (int k = 0; k < 75; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("t5_pe_run", pe_rstn, 1'b1);

    // 6: clear together with watchdog, then async reset in APB_REL
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_vec("t6_cause", rst_cause, 4'b0100);
    for (int k = 0; k < 58; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("t6_apb_up", apb0_rstn, 1'b1);
    check_bit("t6_pe_down", pe_rstn, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("t6_async_sys", sys_rstn, 1'b0);
    check_bit("t6_async_apb1", apb1_rstn, 1'b0);
    check_vec("t6_async_cause", rst_cause, 4'b0001);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(($urandom_range(0, 99) < 97),
           ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
